// File: rtl/fetch_entry_queue.sv
// Multi-lane fetch-entry queue between the frontend and id_stage.
// Up to IN_WIDTH entries enter per cycle; the ISSUE_WIDTH oldest entries are presented in order.
module fetch_entry_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned IN_WIDTH    = 2,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned ENTRY_WIDTH = 64
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    flush_i,
  input  logic [IN_WIDTH-1:0][ENTRY_WIDTH-1:0]    push_entry_i,
  input  logic [IN_WIDTH-1:0]                     push_valid_i,
  output logic                                    push_ready_o,
  output logic [ISSUE_WIDTH-1:0][ENTRY_WIDTH-1:0] fetch_entry_o,
  output logic [ISSUE_WIDTH-1:0]                  fetch_valid_o,
  input  logic [ISSUE_WIDTH-1:0]                  fetch_ready_i,
  output logic [$clog2(DEPTH):0]                  count_o,
  output logic                                    empty_o,
  output logic                                    full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0][ENTRY_WIDTH-1:0] mem_q;
  logic [PtrW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]                   count_q, count_d;
  logic [CntW-1:0]                   n_push, n_pop;
  logic                              pop_run;

  // Space is judged on the registered count alone, so ready never depends on this cycle's pops.
  assign push_ready_o = (count_q <= CntW'(DEPTH - IN_WIDTH));

  always_comb begin
    n_push = '0;
    if (push_ready_o) begin
      for (int j = 0; j < IN_WIDTH; j++) begin
        if (push_valid_i[j]) n_push = n_push + 1'b1;
      end
    end
  end

  // Pop the unbroken run of ready&valid lanes starting at lane 0.
  always_comb begin
    n_pop   = '0;
    pop_run = 1'b1;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (pop_run && fetch_ready_i[k] && fetch_valid_o[k]) begin
        n_pop = n_pop + 1'b1;
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + n_pop[PtrW-1:0];
    wr_ptr_d = wr_ptr_q + n_push[PtrW-1:0];
    count_d  = count_q + n_push - n_pop;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < IN_WIDTH; j++) begin
      if (!flush_i && push_ready_o && push_valid_i[j]) begin
        mem_q[wr_ptr_q + PtrW'(j)] <= push_entry_i[j];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      fetch_entry_o[k] = mem_q[rd_ptr_q + PtrW'(k)];
      fetch_valid_o[k] = (count_q > CntW'(k));
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));

  push_valid_contig_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((push_valid_i + 1'b1) & push_valid_i) == '0);

  fetch_ready_contig_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((fetch_ready_i + 1'b1) & fetch_ready_i) == '0)
    else $warning("fetch_ready_i not contiguous from lane 0: %b", fetch_ready_i);

  count_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count_q <= CntW'(DEPTH)) && (n_pop <= count_q));

  fetch_valid_thermo_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((fetch_valid_o + 1'b1) & fetch_valid_o) == '0);

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Self-checking bench for fetch_entry_queue: directed table, hand-written corner sequences,
// and random traffic against a queue-based reference model.
module tb_fetch_entry_queue;

  localparam int DEPTH = 8;
  localparam int INW   = 2;
  localparam int ISW   = 2;
  localparam int EW    = 64;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] instruction;
  } fe_t;

  typedef struct {
    bit          flush;
    bit [1:0]    pv;
    bit [31:0]   a0;
    bit [31:0]   a1;
    bit [1:0]    rdy;
    int          e_cnt;
    bit [1:0]    e_val;
    bit [31:0]   e_a0;
    bit          e_pr;
  } vec_t;

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic [INW-1:0][EW-1:0]   push_entry;
  logic [INW-1:0]           push_valid;
  logic                     push_ready;
  logic [ISW-1:0][EW-1:0]   fetch_entry;
  logic [ISW-1:0]           fetch_valid;
  logic [ISW-1:0]           fetch_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;

  int checks = 0;
  int errors = 0;
  fe_t mq[$];
  vec_t tbl[14];

  fetch_entry_queue #(
    .DEPTH       (DEPTH),
    .IN_WIDTH    (INW),
    .ISSUE_WIDTH (ISW),
    .ENTRY_WIDTH (EW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .push_entry_i  (push_entry),
    .push_valid_i  (push_valid),
    .push_ready_o  (push_ready),
    .fetch_entry_o (fetch_entry),
    .fetch_valid_o (fetch_valid),
    .fetch_ready_i (fetch_ready),
    .count_o       (count),
    .empty_o       (empty),
    .full_o        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic fe_t mk(input bit [31:0] a);
    fe_t e;
    e.address     = a;
    e.instruction = a ^ 32'hdeadbeef;
    return e;
  endfunction

  // Compare every output against what the model says the queue holds right now.
  task automatic check_model();
    int  n;
    bit [1:0] ev;
    fe_t got;
    n  = mq.size();
    ev = 2'b00;
    for (int k = 0; k < ISW; k++) if (n > k) ev[k] = 1'b1;
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("push_ready", push_ready, (DEPTH - n) >= INW);
    chk("fetch_valid", fetch_valid, ev);
    for (int k = 0; k < ISW; k++) begin
      if (k < n) begin
        got = fetch_entry[k];
        chk($sformatf("entry%0d", k), got, mq[k]);
      end
    end
  endtask

  function automatic void model_update();
    int n;
    int np;
    bit ok;
    if (flush) begin
      mq.delete();
      return;
    end
    n  = mq.size();
    ok = (DEPTH - n) >= INW;
    np = 0;
    for (int k = 0; k < ISW; k++) begin
      if (fetch_ready[k] && k < n) np++;
      else break;
    end
    repeat (np) void'(mq.pop_front());
    if (ok) begin
      for (int j = 0; j < INW; j++) if (push_valid[j]) mq.push_back(fe_t'(push_entry[j]));
    end
  endfunction

  // Inputs are driven at posedge+1; model compared at negedge; model advanced at posedge.
  task automatic cycle(input bit f, input bit [1:0] pv, input bit [31:0] a0, input bit [31:0] a1,
                       input bit [1:0] rdy);
    flush         = f;
    push_valid    = pv;
    push_entry[0] = mk(a0);
    push_entry[1] = mk(a1);
    fetch_ready   = rdy;
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    fe_t got;
    bit [31:0] addr;
    bit [1:0]  pv;
    bit [1:0]  rdy;

    tbl[0]  = '{1'b0, 2'b11, 32'h80, 32'h84, 2'b00, 2, 2'b11, 32'h80, 1'b1};
    tbl[1]  = '{1'b0, 2'b00, 32'h0,  32'h0,  2'b01, 1, 2'b01, 32'h84, 1'b1};
    tbl[2]  = '{1'b0, 2'b00, 32'h0,  32'h0,  2'b10, 1, 2'b01, 32'h84, 1'b1};
    tbl[3]  = '{1'b0, 2'b11, 32'h88, 32'h8c, 2'b00, 3, 2'b11, 32'h84, 1'b1};
    tbl[4]  = '{1'b0, 2'b11, 32'h90, 32'h94, 2'b00, 5, 2'b11, 32'h84, 1'b1};
    tbl[5]  = '{1'b0, 2'b11, 32'h98, 32'h9c, 2'b00, 7, 2'b11, 32'h84, 1'b0};
    tbl[6]  = '{1'b0, 2'b11, 32'ha0, 32'ha4, 2'b11, 5, 2'b11, 32'h8c, 1'b1};
    tbl[7]  = '{1'b0, 2'b01, 32'ha8, 32'h0,  2'b00, 6, 2'b11, 32'h8c, 1'b1};
    tbl[8]  = '{1'b1, 2'b11, 32'hb0, 32'hb4, 2'b11, 0, 2'b00, 32'h0,  1'b1};
    tbl[9]  = '{1'b0, 2'b11, 32'hc0, 32'hc4, 2'b00, 2, 2'b11, 32'hc0, 1'b1};
    tbl[10] = '{1'b0, 2'b11, 32'hc8, 32'hcc, 2'b00, 4, 2'b11, 32'hc0, 1'b1};
    tbl[11] = '{1'b0, 2'b11, 32'hd0, 32'hd4, 2'b00, 6, 2'b11, 32'hc0, 1'b1};
    tbl[12] = '{1'b0, 2'b11, 32'hd8, 32'hdc, 2'b00, 8, 2'b11, 32'hc0, 1'b0};
    tbl[13] = '{1'b1, 2'b00, 32'h0,  32'h0,  2'b00, 0, 2'b00, 32'h0,  1'b1};

    rst_n       = 1'b0;
    flush       = 1'b0;
    push_valid  = '0;
    push_entry  = '0;
    fetch_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].flush, tbl[i].pv, tbl[i].a0, tbl[i].a1, tbl[i].rdy);
      chk($sformatf("tbl%0d.count", i), count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d.valid", i), fetch_valid, tbl[i].e_val);
      chk($sformatf("tbl%0d.push_ready", i), push_ready, tbl[i].e_pr);
      chk($sformatf("tbl%0d.empty", i), empty, tbl[i].e_cnt == 0);
      if (tbl[i].e_cnt > 0) begin
        got = fetch_entry[0];
        chk($sformatf("tbl%0d.addr0", i), got.address, tbl[i].e_a0);
      end
    end

    // Steady push 2 / pop 2: pointers wrap several times, count stays at 2
    addr = 32'h1000;
    cycle(1'b0, 2'b11, addr, addr + 4, 2'b00);
    addr += 8;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 2'b11, addr, addr + 4, 2'b11);
      addr += 8;
      chk("stream.count", count, 2);
      got = fetch_entry[0];
      chk("stream.addr0", got.address, addr - 8);
    end

    // Asynchronous reset in the middle of traffic
    cycle(1'b0, 2'b11, 32'h2000, 32'h2004, 2'b00);
    cycle(1'b0, 2'b11, 32'h2008, 32'h200c, 2'b00);
    push_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("arst.count", count, 0);
    chk("arst.empty", empty, 1);
    chk("arst.valid", fetch_valid, 0);
    chk("arst.push_ready", push_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic against the model
    addr = 32'h4000;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: pv = 2'b00;
        1: pv = 2'b01;
        default: pv = 2'b11;
      endcase
      case ($urandom_range(0, 2))
        0: rdy = 2'b00;
        1: rdy = 2'b01;
        default: rdy = 2'b11;
      endcase
      cycle($urandom_range(0, 24) == 0, pv, addr, addr + 4, rdy);
      addr += 8;
    end
    @(negedge clk);
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
